sa_act_skew_feeder: RTL and testbench

//  Upstream feeder for the 16x16 weight-stationary systolic array.
//  - Accepts one activation vector per handshake (one element per SA row) into a small FIFO.
//  - Pops one vector per cycle and skews it: row i is delayed i cycles, forming the diagonal

---
 rtl/sa_act_skew_feeder.sv | 155 +++++++++++++++
 tb/tb_sa_act_skew_feeder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sa_act_skew_feeder.sv
// Activation feeder for a weight-stationary systolic array: buffers input vectors in a
// small FIFO, pops one per cycle and skews lane i by i cycles into a diagonal wavefront.

module sa_act_skew_lane #(
  parameter int DATA_W = 8,
  parameter int STAGES = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_vld,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_vld,
  output logic [DATA_W-1:0] o_data
);
  logic [STAGES-1:0][DATA_W-1:0] r_data;
  logic [STAGES-1:0]             r_vld_pipe;

  // Shifts every cycle regardless of hold so bubbles keep flowing toward the array.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data     <= '0;
      r_vld_pipe <= '0;
    end else begin
      r_data[0]     <= i_data;
      r_vld_pipe[0] <= i_vld;
      for (int s = 1; s < STAGES; s++) begin
        r_data[s]     <= r_data[s-1];
        r_vld_pipe[s] <= r_vld_pipe[s-1];
      end
    end
  end

  assign o_data = r_data[STAGES-1];
  assign o_vld  = r_vld_pipe[STAGES-1];
endmodule

module sa_act_skew_feeder #(
  parameter int DATA_W     = 8,
  parameter int N          = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  input  logic [N-1:0][DATA_W-1:0]   i_in_act,
  input  logic                       i_in_last,
  input  logic                       i_hold,
  output logic [N-1:0][DATA_W-1:0]   o_act_out,
  output logic [N-1:0]               o_row_valid,
  output logic                       o_valid_out,
  output logic                       o_busy,
  output logic                       o_done
);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int DCNT_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;

  typedef struct packed {
    logic [N-1:0][DATA_W-1:0] act;
    logic                     last;
  } vec_t;

  vec_t                      r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]          r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]          r_count;
  logic [1:0]                r_state;
  logic [DCNT_W-1:0]         r_drain_cnt;
  logic                      r_drain_run;

  logic                      w_push, w_pop, w_pop_last;
  vec_t                      w_head;
  logic [N-1:0][DATA_W-1:0]  w_stage0;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Registered count only: a same-cycle pop never reopens a full FIFO.
  assign o_in_ready = (r_count < CNT_W'(FIFO_DEPTH)) && (r_state != S_DRAIN);
  assign w_push     = i_in_valid & o_in_ready;
  assign w_pop      = (r_count != '0) & ~i_hold;
  assign w_head     = r_mem[r_rd_ptr];
  assign w_pop_last = w_pop & w_head.last;
  assign w_stage0   = w_pop ? w_head.act : '0;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {i_in_act, i_in_last};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Drain counter tracks the last vector across the skew so done lines up with lane N-1.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_drain_cnt <= '0;
      r_drain_run <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_push) r_state <= i_in_last ? S_DRAIN : S_STREAM;
        end
        S_STREAM: begin
          if (w_push && i_in_last) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (o_done) begin
            r_state     <= S_IDLE;
            r_drain_run <= 1'b0;
          end else if (r_drain_run) begin
            r_drain_cnt <= r_drain_cnt - 1'b1;
          end else if (w_pop_last) begin
            r_drain_run <= 1'b1;
            r_drain_cnt <= DCNT_W'(N - 1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_done      = (r_state == S_DRAIN) && r_drain_run && (r_drain_cnt == '0);
  assign o_busy      = (r_state != S_IDLE);
  assign o_valid_out = o_row_valid[0];

  for (genvar g = 0; g < N; g++) begin : g_lane
    sa_act_skew_lane #(.DATA_W(DATA_W), .STAGES(g + 1)) u_lane (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_vld  (w_pop),
      .i_data (w_stage0[g]),
      .o_vld  (o_row_valid[g]),
      .o_data (o_act_out[g])
    );
  end
endmodule

// File: tb/tb_sa_act_skew_feeder.sv
// Bench for sa_act_skew_feeder: directed table, hand sequences and random traffic,
// all checked against a queue/history reference model.

module tb_sa_act_skew_feeder;
  localparam int N = 16, DW = 8, FD = 4, W = N * DW, MAXC = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst, in_valid, in_last, hold;
  logic [N-1:0][DW-1:0]  in_act;
  logic                  in_ready, valid_out, busy, done;
  logic [N-1:0][DW-1:0]  act_out;
  logic [N-1:0]          row_valid;

  sa_act_skew_feeder #(.DATA_W(DW), .N(N), .FIFO_DEPTH(FD)) dut (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_act(in_act), .i_in_last(in_last), .i_hold(hold),
    .o_act_out(act_out), .o_row_valid(row_valid), .o_valid_out(valid_out),
    .o_busy(busy), .o_done(done)
  );

  // Reference model: a FIFO queue plus a per-edge history of what entered the skew.
  typedef struct { logic [N-1:0][DW-1:0] act; bit last; } mvec_t;
  mvec_t                 q[$];
  logic [N-1:0][DW-1:0]  h_act [MAXC];
  bit                    h_vld [MAXC];
  int t = 0, last_rst = -1, last_pop = -1;
  bit m_drain = 0, m_busy = 0, m_done = 0;
  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %h exp %h", nm, t, got, exp);
    end
  endtask

  task automatic model_edge();
    bit rdy, hs, pop;
    mvec_t v;
    if (rst) begin
      q.delete();
      m_drain = 0; m_busy = 0; m_done = 0; last_pop = -1; last_rst = t;
      h_vld[t] = 0; h_act[t] = '0;
    end else begin
      rdy = (q.size() < FD) && !m_drain;
      hs  = in_valid && rdy;
      pop = (q.size() > 0) && !hold;
      h_vld[t] = pop; h_act[t] = '0;
      if (pop) begin
        v = q.pop_front();
        h_act[t] = v.act;
        if (v.last) last_pop = t;
      end
      if (hs) begin
        v.act = in_act; v.last = in_last;
        q.push_back(v);
      end
      if (m_done) begin m_drain = 0; m_busy = 0; last_pop = -1; end
      if (hs) begin m_busy = 1; if (in_last) m_drain = 1; end
      m_done = m_drain && (last_pop >= 0) && (t == last_pop + N - 1);
    end
  endtask

  task automatic check_all();
    logic [N-1:0][DW-1:0] ea;
    logic [N-1:0] er;
    int e;
    ea = '0; er = '0;
    for (int i = 0; i < N; i++) begin
      e = t - i;
      if (e >= 0 && e > last_rst && h_vld[e]) begin ea[i] = h_act[e][i]; er[i] = 1'b1; end
    end
    chk("act_out", act_out, ea);
    chk("row_valid", W'(row_valid), W'(er));
    chk("valid_out", W'(valid_out), W'(er[0]));
    chk("in_ready", W'(in_ready), W'((q.size() < FD) && !m_drain));
    chk("busy", W'(busy), W'(m_busy));
    chk("done", W'(done), W'(m_done));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    t++;
  endtask

  task automatic set_act(input logic [7:0] seed);
    for (int i = 0; i < N; i++) in_act[i] = seed + 8'(i);
  endtask

  task automatic drive(input bit v, input bit l, input bit h, input logic [7:0] seed);
    in_valid = v; in_last = l; hold = h; set_act(seed);
  endtask

  typedef struct {
    bit vld, last, hold, chk_act, e_rdy, e_busy, e_done;
    logic [7:0] seed, e_seed;
    logic [N-1:0] e_rv;
  } row_t;
  row_t tv[$];

  function automatic row_t mk(bit v, bit l, bit h, logic [7:0] s, logic [N-1:0] rv,
                              bit rdy, bit bsy, bit dn, bit ca, logic [7:0] es);
    row_t r;
    r.vld = v; r.last = l; r.hold = h; r.seed = s; r.e_rv = rv;
    r.e_rdy = rdy; r.e_busy = bsy; r.e_done = dn; r.chk_act = ca; r.e_seed = es;
    return r;
  endfunction

  int vcnt, dcnt;
  logic [N-1:0][DW-1:0] xa;

  initial begin
    // T1: single vector 1..16 with last; lane i valid exactly after edge E+1+i.
    tv.push_back(mk(1, 1, 0, 8'd1, '0, 0, 1, 0, 1, 8'd1));
    for (int k = 1; k <= 17; k++)
      tv.push_back(mk(0, 0, 0, 8'd0, (k <= 16) ? N'(1) << (k - 1) : '0,
                      k == 17, k <= 16, k == 16, 1, 8'd1));
    // T3: hold with 5 offers, then release and watch four pops emerge.
    for (int j = 0; j < 4; j++)
      tv.push_back(mk(1, 0, 1, 8'(8'h20 + 16 * j), '0, j < 3, 1, 0, 1, 8'd0));
    tv.push_back(mk(1, 0, 1, 8'h70, '0, 0, 1, 0, 1, 8'd0));
    tv.push_back(mk(0, 0, 0, 8'd0, 16'h0001, 1, 1, 0, 0, 8'd0));
    tv.push_back(mk(0, 0, 0, 8'd0, 16'h0003, 1, 1, 0, 0, 8'd0));
    tv.push_back(mk(0, 0, 0, 8'd0, 16'h0007, 1, 1, 0, 0, 8'd0));
    tv.push_back(mk(0, 0, 0, 8'd0, 16'h000F, 1, 1, 0, 0, 8'd0));
    tv.push_back(mk(0, 0, 0, 8'd0, 16'h001E, 1, 1, 0, 0, 8'd0));
    tv.push_back(mk(0, 0, 0, 8'd0, 16'h003C, 1, 1, 0, 0, 8'd0));

    rst = 1; drive(0, 0, 0, 8'd0);
    tick(); tick();
    rst = 0;

    foreach (tv[k]) begin
      drive(tv[k].vld, tv[k].last, tv[k].hold, tv[k].seed);
      tick();
      chk("tbl_row_valid", W'(row_valid), W'(tv[k].e_rv));
      chk("tbl_in_ready", W'(in_ready), W'(tv[k].e_rdy));
      chk("tbl_busy", W'(busy), W'(tv[k].e_busy));
      chk("tbl_done", W'(done), W'(tv[k].e_done));
      if (tv[k].chk_act) begin
        for (int i = 0; i < N; i++) xa[i] = tv[k].e_rv[i] ? tv[k].e_seed + 8'(i) : 8'd0;
        chk("tbl_act", act_out, xa);
      end
    end

    // T2: six back-to-back vectors, last on the sixth; count valid_out cycles.
    vcnt = 0;
    for (int j = 0; j < 6; j++) begin
      drive(1, j == 5, 0, 8'(8'h80 + 8 * j));
      tick();
      vcnt += int'(valid_out);
    end
    drive(0, 0, 0, 8'd0);
    for (int j = 0; j < 25; j++) begin tick(); vcnt += int'(valid_out); end
    chk("t2_valid_cycles", W'(vcnt), W'(6));

    // T4: A, two idle cycles, then B with last.
    drive(1, 0, 0, 8'h11); tick();
    drive(0, 0, 0, 8'd0);  tick(); tick();
    drive(1, 1, 0, 8'h55); tick();
    drive(0, 0, 0, 8'd0);
    for (int j = 0; j < 22; j++) tick();

    // T5: keep offering after the last vector; acceptance resumes only after done.
    drive(1, 1, 0, 8'h90); tick();
    for (int j = 0; j < 20; j++) begin drive(1, 0, 0, 8'(8'hA0 + j)); tick(); end
    drive(1, 1, 0, 8'hC0); tick();
    drive(0, 0, 0, 8'd0);
    for (int j = 0; j < 25; j++) tick();

    // T6: reset while the wavefront is half way down the lanes; done must never fire.
    drive(1, 1, 0, 8'hD0); tick();
    drive(0, 0, 0, 8'd0);
    for (int j = 0; j < 8; j++) tick();
    rst = 1; tick(); rst = 0;
    chk("t6_act_zero", act_out, '0);
    chk("t6_ready", W'(in_ready), W'(1));
    dcnt = 0;
    for (int j = 0; j < 25; j++) begin tick(); dcnt += int'(done); end
    chk("t6_no_done", W'(dcnt), W'(0));

    // Random traffic with holds, lasts and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      rst      = ($urandom_range(0, 199) == 0);
      in_valid = ($urandom_range(0, 9) < 6);
      in_last  = ($urandom_range(0, 9) == 0);
      hold     = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < N; i++) in_act[i] = 8'($urandom);
      tick();
    end
    rst = 0; drive(0, 0, 0, 8'd0);
    for (int j = 0; j < 30; j++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
